instr_prefetch_buffer: RTL
==========================

# instr_prefetch_buffer

Decoupled instruction-fetch stage that sits directly upstream of the pipelined CPU's IF/ID register. It issues sequential fetches to a variable-latency instruction memory over a req/ack handshake. It buffers fetched `{pc, instr}` pairs in a small FIFO and presents them to decode with a valid/ready handshake. On a taken-branch redirect from EX it flushes the queue and restarts fetching at the target address, discarding any in-flight response.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; word-aligned.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word; sampled only when `imem_ack`=1.
- `redirect` in 1: flush and restart (branch taken in EX).
- `redirect_pc` in 32: restart address; bits [1:0] ignored and forced to 0.
- `out_valid` out 1: head entry available to decode.
- `out_instr` out 32: head instruction; 32'h0 when `out_valid`=0.
- `out_pc` out 32: head PC; 32'h0 when `out_valid`=0.
- `out_ready` in 1: decode accepts the head (de-asserted by the hazard stall).

## Operation

- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - FIFO count=0, fetch_pc=RESET_PC, state=REQ.
- States:
  - **IDLE**: FIFO full, `imem_req`=0.
  - **REQ**: `imem_req`=1 with `imem_addr`=fetch_pc.
  - **DISCARD**: a request is outstanding whose response must be dropped.
- Handshake rule: once `imem_req` is asserted, `imem_req` and `imem_addr` stay stable until `imem_ack`. A request is never withdrawn.
- REQ, ack, no redirect:
  - Push `{fetch_pc, imem_rdata}`; fetch_pc += 4 (mod 2^32).
  - Go to IDLE if count after push and pop = DEPTH, else stay in REQ; back-to-back requests are allowed.
- REQ is entered only when count < DEPTH, so every ack has a free slot.
- IDLE → REQ in the cycle after count drops below DEPTH.
- Pop whenever `out_valid && out_ready`. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority), regardless of state:
  - FIFO count ← 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - Any ack in the same cycle is dropped.
- Next state after a redirect:
  - REQ, if no request was pending or it was acked that cycle.
  - DISCARD, if `imem_req`=1 and `imem_ack`=0.
- DISCARD:
  - Keep the old req/addr until ack, then drop the data and go to REQ at fetch_pc.
  - A further redirect while in DISCARD updates fetch_pc and stays in DISCARD.
- A redirect while in IDLE goes to REQ.

## Timing

- Ack in cycle M: entry is visible (`out_valid`=1) in cycle M+1 when the FIFO was empty; the FIFO is registered and has no bypass.
- Redirect in cycle N:
  - `out_valid`=0 in N+1.
  - `imem_req` with the target address in N+1 if no response is outstanding.
- Sustained throughput: 1 instruction per cycle with single-cycle acks and `out_ready`=1.
- Read pointer, write pointer and count are `$clog2(DEPTH)`, `$clog2(DEPTH)` and `$clog2(DEPTH)+1` bits wide; pointers wrap modulo DEPTH.

## Structure

- Shared package `pipe_pkg`:
  - `XLEN`=32.
  - `BUBBLE_INSTR`=32'h0.
  - `fetch_state_e` {IDLE, REQ, DISCARD}.
  - Packed struct `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo`: parameterized DEPTH storage with push/pop/flush, count, full, empty and head outputs.
- The FSM and fetch_pc live in the top module.

## Test plan

- **Reset**: hold `reset`=1 for 2 cycles with `imem_ack`=1 → `imem_req`=0, `out_valid`=0. The first request after release has `imem_addr`=0x0.
- **Streaming**: single-cycle acks returning 0x11,0x22,0x33, `out_ready`=1 → outputs {0x0,0x11},{0x4,0x22},{0x8,0x33} on consecutive cycles, each one cycle after its ack.
- **Backpressure**: `out_ready`=0, DEPTH=4 → after 4 acks `imem_req`=0 and count=4. Raising `out_ready` for one cycle resumes requests at addr 0x10.
- **Redirect with outstanding request**: request to 0x8 pending, ack delayed 3 cycles, redirect to 0x103 →
  - `imem_addr` holds 0x8 until ack and that data is dropped.
  - The next request goes to 0x100.
  - The first `out_pc` after the flush is 0x100.
- **Redirect with simultaneous ack and pop**: redirect to 0x40 in the same cycle as ack and pop → FIFO empty next cycle, `imem_req`=1 with addr 0x40, no stale entry emitted.
- **Wrap-around**: RESET_PC=32'hFFFF_FFFC with 2 acks → `out_pc` sequence 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch front end: the fetch FSM encoding and the
// {pc, instr} pair that travels from instruction memory to decode.
package pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetched {pc, instr} pairs; flush empties it in one cycle.
// The head is read straight from storage, so a push becomes visible one cycle later.
module fetch_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      count = count_q;
      head  = mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Decoupled instruction fetch: sequential req/ack fetches into a small FIFO feeding
// decode, with branch redirect flushing the queue and dropping any in-flight response.
module instr_prefetch_buffer
   import pipe_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   input  logic                     out_ready,
   output logic [1:0]               dbg_state,
   output logic [$clog2(DEPTH):0]   dbg_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshakes: a memory transfer happens on a cycle with imem_req && imem_ack;
   // once raised, imem_req/imem_addr hold until that cycle. Decode transfers on
   // out_valid && out_ready; out_valid never depends on out_ready.

   fetch_state_e       state_q, state_d;
   logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]    hold_addr_q, hold_addr_d;

   logic               fire;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   always_comb begin
      imem_req  = !reset && (state_q == REQ || state_q == DISCARD);
      imem_addr = (state_q == DISCARD) ? hold_addr_q : fetch_pc_q;
      fire      = imem_req && imem_ack;
      pop       = out_valid && out_ready && !redirect;
   end

   always_comb begin
      state_d          = state_q;
      fetch_pc_d       = fetch_pc_q;
      hold_addr_d      = hold_addr_q;
      push             = 1'b0;
      push_entry.pc    = fetch_pc_q;
      push_entry.instr = imem_rdata;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         if (imem_req && !imem_ack) begin
            state_d = DISCARD;
            // From DISCARD the held address already belongs to the outstanding request.
            if (state_q == REQ) begin
               hold_addr_d = fetch_pc_q;
            end
         end else begin
            state_d = REQ;
         end
      end else begin
         unique case (state_q)
            REQ: begin
               if (fire) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (fifo_count == CW'(DEPTH - 1) && !pop) begin
                     state_d = IDLE;
                  end
               end
            end
            IDLE: begin
               if (!fifo_full) begin
                  state_d = REQ;
               end
            end
            DISCARD: begin
               if (fire) begin
                  state_d = REQ;
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= REQ;
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .head       (head)
   );

   always_comb begin
      out_valid = !fifo_empty;
      out_instr = out_valid ? head.instr : BUBBLE_INSTR;
      out_pc    = out_valid ? head.pc : '0;
      dbg_state = state_q;
      dbg_count = fifo_count;
   end

endmodule
